qu_rob_multi: RTL and testbench

- Parametrised reorder buffer for the Qu out-of-order core; successor to the fixed 8-entry, single-retire ROB.
- Allocates entries in program order at dispatch and accepts out-of-order results from execution writeback.
- Retires up to RETIRE_WIDTH completed entries per cycle, in order, and flushes itself when a mispredicted branch retires.
- Sits between dispatch/rename and commit (physical register free list, data memory store port).

---
 rtl/qu_rob_multi_if.sv | 44 ++++
 rtl/qu_rob_multi.sv | 90 +++++++++
 tb/tb_qu_rob_multi.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/qu_rob_multi_if.sv
// qu_rob_multi_if: dispatch, writeback and commit bundle of the multi-retire reorder buffer
interface qu_rob_multi_if #(
  parameter int DEPTH = 8,
  parameter int RETIRE_WIDTH = 2,
  parameter int DATA_WIDTH = 32,
  parameter int PHY_ADDR_WIDTH = 7
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic alloc_valid;
  logic alloc_ready;
  logic [AW-1:0] alloc_tag;
  logic [PHY_ADDR_WIDTH-1:0] alloc_phyreg_old;
  logic [31:0] alloc_dest;
  logic alloc_load;
  logic alloc_store;
  logic [2:0] alloc_funct3;
  logic wb_valid;
  logic [AW-1:0] wb_tag;
  logic [DATA_WIDTH-1:0] wb_value;
  logic wb_mispredict;
  logic ret_ready;
  logic [RETIRE_WIDTH-1:0] ret_valid;
  logic [RETIRE_WIDTH*DATA_WIDTH-1:0] ret_value;
  logic [RETIRE_WIDTH*32-1:0] ret_dest;
  logic [RETIRE_WIDTH*PHY_ADDR_WIDTH-1:0] ret_phyreg_old;
  logic [RETIRE_WIDTH-1:0] ret_load;
  logic [RETIRE_WIDTH-1:0] ret_store;
  logic [RETIRE_WIDTH*3-1:0] ret_funct3;
  logic flush;
  logic [CW-1:0] count;
  modport master (
    output alloc_valid, alloc_phyreg_old, alloc_dest, alloc_load, alloc_store, alloc_funct3,
    output wb_valid, wb_tag, wb_value, wb_mispredict, ret_ready,
    input alloc_ready, alloc_tag, ret_valid, ret_value, ret_dest, ret_phyreg_old,
    input ret_load, ret_store, ret_funct3, flush, count
  );
  modport slave (
    input alloc_valid, alloc_phyreg_old, alloc_dest, alloc_load, alloc_store, alloc_funct3,
    input wb_valid, wb_tag, wb_value, wb_mispredict, ret_ready,
    output alloc_ready, alloc_tag, ret_valid, ret_value, ret_dest, ret_phyreg_old,
    output ret_load, ret_store, ret_funct3, flush, count
  );
endinterface

// File: rtl/qu_rob_multi.sv
// qu_rob_multi: reorder buffer with in-order multi-entry retire and flush on mispredicted branch
module qu_rob_multi #(
  parameter int DEPTH = 8,
  parameter int RETIRE_WIDTH = 2,
  parameter int DATA_WIDTH = 32,
  parameter int PHY_ADDR_WIDTH = 7
) (
  input logic clk,
  input logic rst_n,
  qu_rob_multi_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {EMPTY = 2'b00, EXECUTE = 2'b10, RETIRED = 2'b01} state_e;
  state_e st [DEPTH];
  logic [DATA_WIDTH-1:0] val [DEPTH];
  logic misp [DEPTH];
  logic [31:0] dest [DEPTH];
  logic [PHY_ADDR_WIDTH-1:0] pold [DEPTH];
  logic ld [DEPTH];
  logic sto [DEPTH];
  logic [2:0] f3 [DEPTH];
  logic [AW-1:0] head, tail, idx;
  logic [CW-1:0] cnt, n_ret;
  logic ok, mis, fire;
  assign bus.alloc_tag = tail;
  assign bus.count = cnt;
  assign bus.flush = bus.ret_ready && mis;
  assign bus.alloc_ready = (cnt != CW'(DEPTH)) && !bus.flush;
  assign fire = bus.alloc_valid && bus.alloc_ready;
  // a slot retires only if every older slot does and none of them is a mispredict
  always_comb begin
    idx = '0;
    ok = 1'b1;
    mis = 1'b0;
    n_ret = '0;
    bus.ret_valid = '0;
    bus.ret_value = '0;
    bus.ret_dest = '0;
    bus.ret_phyreg_old = '0;
    bus.ret_load = '0;
    bus.ret_store = '0;
    bus.ret_funct3 = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      idx = head + AW'(i);
      if (ok && st[idx] == RETIRED && CW'(i) < cnt) begin
        bus.ret_valid[i] = 1'b1;
        n_ret = n_ret + 1'b1;
        mis = misp[idx];
        ok = !misp[idx];
      end else ok = 1'b0;
      bus.ret_value[i*DATA_WIDTH +: DATA_WIDTH] = val[idx];
      bus.ret_dest[i*32 +: 32] = dest[idx];
      bus.ret_phyreg_old[i*PHY_ADDR_WIDTH +: PHY_ADDR_WIDTH] = pold[idx];
      bus.ret_load[i] = ld[idx];
      bus.ret_store[i] = sto[idx];
      bus.ret_funct3[i*3 +: 3] = f3[idx];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      for (int i = 0; i < DEPTH; i++) st[i] <= EMPTY;
      head <= '0;
      tail <= '0;
      cnt <= '0;
    end else begin
      if (bus.ret_ready) begin
        for (int i = 0; i < RETIRE_WIDTH; i++)
          if (bus.ret_valid[i]) st[head + AW'(i)] <= EMPTY;
        head <= head + AW'(n_ret);
      end
      if (bus.wb_valid && st[bus.wb_tag] == EXECUTE) begin
        st[bus.wb_tag] <= RETIRED;
        val[bus.wb_tag] <= bus.wb_value;
        misp[bus.wb_tag] <= bus.wb_mispredict;
      end
      if (fire) begin
        st[tail] <= EXECUTE;
        misp[tail] <= 1'b0;
        dest[tail] <= bus.alloc_dest;
        pold[tail] <= bus.alloc_phyreg_old;
        ld[tail] <= bus.alloc_load;
        sto[tail] <= bus.alloc_store;
        f3[tail] <= bus.alloc_funct3;
        tail <= tail + 1'b1;
      end
      cnt <= cnt + CW'(fire) - (bus.ret_ready ? n_ret : '0);
    end
  end
endmodule

// File: tb/tb_qu_rob_multi.sv
// tb_qu_rob_multi: directed scenario checks of the reorder buffer with DEPTH=8, RETIRE_WIDTH=2
module tb_qu_rob_multi;
  logic clk;
  logic rst_n;
  int checks;
  int failures;
  qu_rob_multi_if #(.DEPTH(8), .RETIRE_WIDTH(2), .DATA_WIDTH(32), .PHY_ADDR_WIDTH(7)) bus ();
  qu_rob_multi #(.DEPTH(8), .RETIRE_WIDTH(2), .DATA_WIDTH(32), .PHY_ADDR_WIDTH(7)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.alloc_valid = 1'b0;
    bus.alloc_phyreg_old = '0;
    bus.alloc_dest = '0;
    bus.alloc_load = 1'b0;
    bus.alloc_store = 1'b0;
    bus.alloc_funct3 = '0;
    bus.wb_valid = 1'b0;
    bus.wb_tag = '0;
    bus.wb_value = '0;
    bus.wb_mispredict = 1'b0;
    bus.ret_ready = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  task automatic alloc(input logic [31:0] d);
    bus.alloc_valid = 1'b1;
    bus.alloc_dest = d;
    bus.alloc_phyreg_old = d[6:0];
    bus.alloc_funct3 = d[2:0];
    tick();
    bus.alloc_valid = 1'b0;
  endtask
  task automatic wb(input logic [2:0] tag, input logic [31:0] v, input logic m);
    bus.wb_valid = 1'b1;
    bus.wb_tag = tag;
    bus.wb_value = v;
    bus.wb_mispredict = m;
    tick();
    bus.wb_valid = 1'b0;
    bus.wb_mispredict = 1'b0;
  endtask
  task automatic test_reset();
    idle();
    do_reset();
    checks += 5;
    if (bus.count !== 4'd0) begin failures++; $display("FAIL reset_count got %0d want 0", bus.count); end
    if (bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL reset_alloc_ready got %b want 1", bus.alloc_ready); end
    if (bus.alloc_tag !== 3'd0) begin failures++; $display("FAIL reset_alloc_tag got %0d want 0", bus.alloc_tag); end
    if (bus.ret_valid !== 2'b00) begin failures++; $display("FAIL reset_ret_valid got %b want 00", bus.ret_valid); end
    if (bus.flush !== 1'b0) begin failures++; $display("FAIL reset_flush got %b want 0", bus.flush); end
  endtask
  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.alloc_valid = 1'b1;
      bus.alloc_dest = 32'(i);
      #1;
      checks++;
      if (bus.alloc_tag !== 3'(i)) begin failures++; $display("FAIL fill_tag got %0d want %0d", bus.alloc_tag, i); end
      tick();
    end
    checks += 2;
    if (bus.count !== 4'd8) begin failures++; $display("FAIL fill_count got %0d want 8", bus.count); end
    if (bus.alloc_ready !== 1'b0) begin failures++; $display("FAIL fill_ready got %b want 0", bus.alloc_ready); end
    tick();
    bus.alloc_valid = 1'b0;
    checks += 2;
    if (bus.count !== 4'd8) begin failures++; $display("FAIL fill_ninth_count got %0d want 8", bus.count); end
    if (bus.alloc_tag !== 3'd0) begin failures++; $display("FAIL fill_ninth_tag got %0d want 0", bus.alloc_tag); end
  endtask
  task automatic test_partial_retire();
    do_reset();
    for (int i = 0; i < 3; i++) alloc(32'(100 + i));
    wb(3'd2, 32'h22, 1'b0);
    wb(3'd0, 32'hA5, 1'b0);
    bus.ret_ready = 1'b1;
    #1;
    checks += 4;
    if (bus.ret_valid !== 2'b01) begin failures++; $display("FAIL partial_valid got %b want 01", bus.ret_valid); end
    if (bus.ret_value[31:0] !== 32'hA5) begin failures++; $display("FAIL partial_value got %h want a5", bus.ret_value[31:0]); end
    if (bus.ret_dest[31:0] !== 32'd100) begin failures++; $display("FAIL partial_dest got %0d want 100", bus.ret_dest[31:0]); end
    if (bus.ret_phyreg_old[6:0] !== 7'd100) begin failures++; $display("FAIL partial_pold got %0d want 100", bus.ret_phyreg_old[6:0]); end
    tick();
    checks += 2;
    if (bus.count !== 4'd2) begin failures++; $display("FAIL partial_count got %0d want 2", bus.count); end
    if (bus.ret_valid !== 2'b00) begin failures++; $display("FAIL partial_blocked got %b want 00", bus.ret_valid); end
    wb(3'd1, 32'h11, 1'b0);
    checks += 3;
    if (bus.ret_valid !== 2'b11) begin failures++; $display("FAIL pair_valid got %b want 11", bus.ret_valid); end
    if (bus.ret_value[31:0] !== 32'h11) begin failures++; $display("FAIL pair_value0 got %h want 11", bus.ret_value[31:0]); end
    if (bus.ret_value[63:32] !== 32'h22) begin failures++; $display("FAIL pair_value1 got %h want 22", bus.ret_value[63:32]); end
    tick();
    bus.ret_ready = 1'b0;
    checks++;
    if (bus.count !== 4'd0) begin failures++; $display("FAIL pair_count got %0d want 0", bus.count); end
  endtask
  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 6; i++) alloc(32'(i));
    for (int i = 0; i < 6; i++) wb(3'(i), 32'(i), 1'b0);
    bus.ret_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.ret_ready = 1'b0;
    checks += 2;
    if (bus.count !== 4'd0) begin failures++; $display("FAIL wrap_drain_count got %0d want 0", bus.count); end
    if (bus.alloc_tag !== 3'd6) begin failures++; $display("FAIL wrap_tail got %0d want 6", bus.alloc_tag); end
    alloc(32'h6);
    alloc(32'h7);
    alloc(32'h8);
    wb(3'd6, 32'h60, 1'b0);
    wb(3'd7, 32'h70, 1'b0);
    wb(3'd0, 32'h80, 1'b0);
    bus.ret_ready = 1'b1;
    #1;
    checks += 3;
    if (bus.ret_valid !== 2'b11) begin failures++; $display("FAIL wrap_valid1 got %b want 11", bus.ret_valid); end
    if (bus.ret_value[31:0] !== 32'h60) begin failures++; $display("FAIL wrap_value0 got %h want 60", bus.ret_value[31:0]); end
    if (bus.ret_value[63:32] !== 32'h70) begin failures++; $display("FAIL wrap_value1 got %h want 70", bus.ret_value[63:32]); end
    tick();
    checks += 3;
    if (bus.ret_valid !== 2'b01) begin failures++; $display("FAIL wrap_valid2 got %b want 01", bus.ret_valid); end
    if (bus.ret_value[31:0] !== 32'h80) begin failures++; $display("FAIL wrap_value2 got %h want 80", bus.ret_value[31:0]); end
    if (bus.count !== 4'd1) begin failures++; $display("FAIL wrap_count1 got %0d want 1", bus.count); end
    tick();
    bus.ret_ready = 1'b0;
    checks += 2;
    if (bus.count !== 4'd0) begin failures++; $display("FAIL wrap_count0 got %0d want 0", bus.count); end
    if (bus.ret_valid !== 2'b00) begin failures++; $display("FAIL wrap_empty got %b want 00", bus.ret_valid); end
  endtask
  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 6; i++) alloc(32'(i));
    for (int i = 0; i < 3; i++) wb(3'(i), 32'(i), 1'b0);
    bus.ret_ready = 1'b1;
    tick();
    tick();
    bus.ret_ready = 1'b0;
    checks++;
    if (bus.count !== 4'd3) begin failures++; $display("FAIL flush_pre_count got %0d want 3", bus.count); end
    wb(3'd3, 32'h33, 1'b1);
    wb(3'd4, 32'h44, 1'b0);
    wb(3'd5, 32'h55, 1'b0);
    bus.ret_ready = 1'b1;
    bus.alloc_valid = 1'b1;
    #1;
    checks += 4;
    if (bus.ret_valid !== 2'b01) begin failures++; $display("FAIL flush_valid got %b want 01", bus.ret_valid); end
    if (bus.flush !== 1'b1) begin failures++; $display("FAIL flush_strobe got %b want 1", bus.flush); end
    if (bus.alloc_ready !== 1'b0) begin failures++; $display("FAIL flush_alloc_ready got %b want 0", bus.alloc_ready); end
    if (bus.ret_value[31:0] !== 32'h33) begin failures++; $display("FAIL flush_value got %h want 33", bus.ret_value[31:0]); end
    tick();
    bus.ret_ready = 1'b0;
    bus.alloc_valid = 1'b0;
    #1;
    checks += 4;
    if (bus.count !== 4'd0) begin failures++; $display("FAIL flush_count got %0d want 0", bus.count); end
    if (bus.alloc_tag !== 3'd0) begin failures++; $display("FAIL flush_tag got %0d want 0", bus.alloc_tag); end
    if (bus.flush !== 1'b0) begin failures++; $display("FAIL flush_after got %b want 0", bus.flush); end
    if (bus.ret_valid !== 2'b00) begin failures++; $display("FAIL flush_ret_after got %b want 00", bus.ret_valid); end
  endtask
  task automatic test_hold();
    do_reset();
    alloc(32'h1);
    alloc(32'h2);
    wb(3'd0, 32'hB0, 1'b0);
    wb(3'd1, 32'hB1, 1'b0);
    checks++;
    if (bus.ret_valid !== 2'b11) begin failures++; $display("FAIL hold_valid got %b want 11", bus.ret_valid); end
    tick();
    checks += 2;
    if (bus.ret_valid !== 2'b11) begin failures++; $display("FAIL hold_stable got %b want 11", bus.ret_valid); end
    if (bus.count !== 4'd2) begin failures++; $display("FAIL hold_count got %0d want 2", bus.count); end
    bus.ret_ready = 1'b1;
    tick();
    bus.ret_ready = 1'b0;
    checks++;
    if (bus.count !== 4'd0) begin failures++; $display("FAIL hold_release got %0d want 0", bus.count); end
  endtask
  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) alloc(32'(i));
    wb(3'd0, 32'hC0, 1'b0);
    wb(3'd1, 32'hC1, 1'b0);
    do_reset();
    checks += 3;
    if (bus.count !== 4'd0) begin failures++; $display("FAIL mreset_count got %0d want 0", bus.count); end
    if (bus.ret_valid !== 2'b00) begin failures++; $display("FAIL mreset_valid got %b want 00", bus.ret_valid); end
    if (bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL mreset_ready got %b want 1", bus.alloc_ready); end
    wb(3'd2, 32'h77, 1'b0);
    for (int i = 0; i < 3; i++) alloc(32'(i));
    wb(3'd0, 32'hD0, 1'b0);
    checks += 2;
    if (bus.count !== 4'd3) begin failures++; $display("FAIL late_wb_count got %0d want 3", bus.count); end
    if (bus.ret_valid !== 2'b01) begin failures++; $display("FAIL late_wb_valid got %b want 01", bus.ret_valid); end
  endtask
  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    idle();
    test_reset();
    test_fill();
    test_partial_retire();
    test_wrap();
    test_flush();
    test_hold();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
